// File: rtl/bus_valid_ready_delay.sv
// -----------------------------------------------------------------------------
// bus_valid_ready_delay
//
// Full register slice for a valid/ready stream. It adds one register stage in
// the forward path (valid/data) and one in the backward path (ready). Storage
// is a main register that drives the outputs, plus a single skid register. The
// skid register catches the word that upstream launches in the same cycle that
// downstream stalls.
//
// Ports
//   clk      : clock; all state updates on the rising edge
//   rst_n    : asynchronous reset, active HIGH (the name is historical)
//   valid_i  : upstream valid
//   data_i   : upstream payload, Width bits
//   ready_o  : ready returned to upstream (registered; equals NOT skid valid)
//   valid_o  : downstream valid (registered)
//   data_o   : downstream payload, Width bits (registered)
//   ready_i  : downstream ready
// -----------------------------------------------------------------------------
module bus_valid_ready_delay #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    input  logic             ready_i
);

    logic             r_main_vld;
    logic [Width-1:0] r_main_data;
    logic             r_skid_vld;
    logic [Width-1:0] r_skid_data;
    logic             r_ready;

    logic w_up_xfer;
    logic w_dn_xfer;
    logic w_main_free;

    assign w_up_xfer   = valid_i & r_ready;
    assign w_dn_xfer   = r_main_vld & ready_i;
    // The main register can take a new word when it is empty or drains this edge.
    assign w_main_free = ~r_main_vld | ready_i;

    // ---- register stage: main + skid -----------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_main_vld  <= 1'b0;
            r_main_data <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_ready     <= 1'b1;
        end else if (w_main_free) begin
            // The skid word is older than anything upstream, so it goes first.
            // While skid is valid ready_o is 0, so no upstream word competes.
            if (r_skid_vld) begin
                r_main_vld  <= 1'b1;
                r_main_data <= r_skid_data;
                r_skid_vld  <= 1'b0;
                r_ready     <= 1'b1;
            end else if (w_up_xfer) begin
                r_main_vld  <= 1'b1;
                r_main_data <= data_i;
            end else begin
                r_main_vld  <= 1'b0;
            end
        end else if (w_up_xfer) begin
            // Main is full and stalled: the word accepted this edge parks in skid.
            r_skid_vld  <= 1'b1;
            r_skid_data <= data_i;
            r_ready     <= 1'b0;
        end
    end

    assign valid_o = r_main_vld;
    assign data_o  = r_main_data;
    assign ready_o = r_ready;

`ifndef SYNTHESIS
    // Occupancy tracked independently of the storage: it must always equal the
    // number of held entries. That rules out both lost and duplicated words.
    logic [1:0] r_sim_occ;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_sim_occ <= 2'd0;
        end else begin
            r_sim_occ <= r_sim_occ + 2'(w_up_xfer) - 2'(w_dn_xfer);
        end
    end

    a_occupancy: assert property (@(posedge clk) disable iff (rst_n)
        r_sim_occ == (2'(r_main_vld) + 2'(r_skid_vld)));

    // Skid only ever holds the younger word, so it implies a full main register.
    a_order: assert property (@(posedge clk) disable iff (rst_n)
        r_skid_vld |-> r_main_vld);

    a_ready_skid: assert property (@(posedge clk) disable iff (rst_n)
        r_ready == !r_skid_vld);

    a_stall_stable: assert property (@(posedge clk) disable iff (rst_n)
        (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));
`endif

endmodule

// File: tb/tb_bus_valid_ready_delay.sv
// -----------------------------------------------------------------------------
// tb_bus_valid_ready_delay
//
// Self-checking bench for bus_valid_ready_delay. A table of per-cycle vectors
// covers the fill/stall/release corner. Hand-written sequences cover continuous
// flow, alternating backpressure and reset mid-stream. A queue scoreboard
// follows every accepted word through to delivery.
// -----------------------------------------------------------------------------
module tb_bus_valid_ready_delay;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         valid_i;
    logic [W-1:0] data_i;
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] data_o;
    logic         ready_i;

    int checks   = 0;
    int failures = 0;
    int delivered = 0;
    logic last_acc;

    logic [W-1:0] sb_q[$];

    bus_valid_ready_delay #(.Width(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         exp_vld;
        logic         chk_data;
        logic [W-1:0] exp_data;
        logic         exp_rdy;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge. It drives inputs, scores the transfers that will
    // happen on the next rising edge, waits for that edge, checks stall
    // stability and returns at the following falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
        logic         stalled;
        logic [W-1:0] held;
        logic [W-1:0] exp;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        #1;
        last_acc = 1'b0;
        stalled  = 1'b0;
        held     = data_o;
        if (!rst_n) begin
            if (valid_o && ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_word", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    exp = sb_q.pop_front();
                    chk("sb_data", 32'(data_o), 32'(exp));
                    delivered++;
                end
            end
            if (valid_i && ready_o) begin
                sb_q.push_back(data_i);
                last_acc = 1'b1;
            end
            stalled = valid_o && !ready_i;
        end
        @(posedge clk);
        #1;
        if (stalled && !rst_n) begin
            chk("stall_valid", 32'(valid_o), 32'd1);
            chk("stall_data", 32'(data_o), 32'(held));
        end
        @(negedge clk);
    endtask

    initial begin
        int idx;
        int cyc;

        // {v, d, r, exp_vld, chk_data, exp_data, exp_rdy}: fill, stall, release
        tbl[0] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h05, 1'b1};
        tbl[1] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0};
        tbl[2] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0};
        tbl[3] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0};
        tbl[4] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h06, 1'b1};
        tbl[5] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1};
        tbl[6] = '{1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[7] = '{1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[8] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};

        rst_n   = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'h3C;
        ready_i = 1'b1;
        last_acc = 1'b0;

        // Reset state, with a transfer offered during reset that must be dropped
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid_o", 32'(valid_o), 32'd0);
        chk("reset_ready_o", 32'(ready_o), 32'd1);
        chk("reset_data_o", 32'(data_o), 32'd0);
        valid_i = 1'b0;
        rst_n   = 1'b0;

        // Table: fill with 5 and 6, 7 refused, then release 5, 6, 7 in order
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_valid_o", i), 32'(valid_o), 32'(tbl[i].exp_vld));
            chk($sformatf("tbl%0d_ready_o", i), 32'(ready_o), 32'(tbl[i].exp_rdy));
            if (tbl[i].chk_data)
                chk($sformatf("tbl%0d_data_o", i), 32'(data_o), 32'(tbl[i].exp_data));
        end
        chk("tbl_sb_empty", 32'(sb_q.size()), 32'd0);

        // Continuous flow: one word per cycle, one cycle of latency
        for (int i = 0; i <= 12; i++) begin
            cycle(1'b1, W'(i), 1'b1);
            chk($sformatf("flow%0d_valid_o", i), 32'(valid_o), 32'd1);
            chk($sformatf("flow%0d_data_o", i), 32'(data_o), 32'(i));
            chk($sformatf("flow%0d_ready_o", i), 32'(ready_o), 32'd1);
        end
        cycle(1'b0, '0, 1'b1);
        chk("flow_drained", 32'(valid_o), 32'd0);
        chk("flow_sb_empty", 32'(sb_q.size()), 32'd0);

        // Alternating backpressure: each word is offered until it is accepted
        delivered = 0;
        idx = 0;
        cyc = 0;
        while (idx <= 12 && cyc < 100) begin
            cycle(1'b1, W'(idx), cyc[0] ? 1'b0 : 1'b1);
            if (last_acc) idx++;
            cyc++;
        end
        chk("alt_all_sent", 32'(idx), 32'd13);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        chk("alt_delivered", 32'(delivered), 32'd13);
        chk("alt_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("alt_idle_valid", 32'(valid_o), 32'd0);

        // Reset mid-stream with both entries full
        cycle(1'b1, 8'h05, 1'b0);
        cycle(1'b1, 8'h06, 1'b0);
        chk("full_ready_o", 32'(ready_o), 32'd0);
        chk("full_data_o", 32'(data_o), 32'h05);
        #2;
        rst_n = 1'b1;
        sb_q.delete();
        #1;
        chk("async_rst_valid_o", 32'(valid_o), 32'd0);
        chk("async_rst_ready_o", 32'(ready_o), 32'd1);
        chk("async_rst_data_o", 32'(data_o), 32'd0);
        @(negedge clk);
        cycle(1'b1, 8'h33, 1'b1);
        chk("in_rst_valid_o", 32'(valid_o), 32'd0);
        rst_n = 1'b0;
        cycle(1'b1, 8'h0A, 1'b1);
        chk("post_rst_valid_o", 32'(valid_o), 32'd1);
        chk("post_rst_data_o", 32'(data_o), 32'h0A);
        chk("post_rst_ready_o", 32'(ready_o), 32'd1);
        cycle(1'b0, '0, 1'b1);
        chk("post_rst_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("post_rst_idle", 32'(valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
